odd_parity_serial_tx: RTL

- Serial frame transmitter that sequences the odd-parity function over a parallel word.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts out a frame: start(0), data LSB-first, odd parity bit, stop(1).
- Each bit is held for BAUD_DIV clocks.
- Sits between the parallel producer and the serial line driver. Parity is generated incrementally as the bits are shifted out.

---
 rtl/odd_parity_serial_tx_pkg.sv | 37 +++
 rtl/odd_parity_serial_tx_baud_tick_gen.sv | 34 +++
 rtl/odd_parity_serial_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/odd_parity_serial_tx_pkg.sv
// Shared definitions for the odd-parity serial transmitter: FSM encoding,
// line idle level and small width/parity helper functions.
package odd_parity_serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic TX_IDLE_LVL = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counters need at least one bit even when the count range collapses to one value.
    function automatic int cnt_width(input int value);
        int w;
        w = clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic parity_step(input logic acc, input logic data_bit);
        return acc ^ data_bit;
    endfunction

endpackage

// File: rtl/odd_parity_serial_tx_baud_tick_gen.sv
// Bit-period timer: tick is high on the last clock of every BAUD_DIV-clock
// bit period; clear restarts the period so a frame starts phase-aligned.
module odd_parity_serial_tx_baud_tick_gen
    import odd_parity_serial_tx_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Period counter, wrapping to zero at every bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Frame transmitter: start(0), DATA_W data bits LSB-first, odd parity, stop(1),
// each bit held for BAUD_DIV clocks; parity is accumulated as bits leave.
module odd_parity_serial_tx
    import odd_parity_serial_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = cnt_width(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_s;
    logic [BW-1:0]     bit_cnt_r;
    logic [BW-1:0]     bit_cnt_s;
    logic              parity_r;
    logic              parity_s;
    logic              tx_r;
    logic              tx_s;
    logic              done_r;
    logic              done_s;
    logic              accept_s;
    logic              tick_s;

    assign accept_s = in_valid && (state_r == ST_IDLE);

    odd_parity_serial_tx_baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (accept_s),
        .tick  (tick_s)
    );

    // Next-state, shift, bit count and parity accumulation.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_cnt_s = bit_cnt_r;
        parity_s  = parity_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s   = ST_START;
                    shreg_s   = in_data;
                    parity_s  = 1'b1;
                    bit_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    parity_s = parity_step(parity_r, shreg_r[0]);
                    shreg_s  = shreg_r >> 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s   = ST_PARITY;
                        bit_cnt_s = '0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                shreg_s   = '0;
                bit_cnt_s = '0;
                parity_s  = 1'b0;
            end
        endcase
    end

    // Line level for the coming cycle, decoded from the next state so tx is a flop.
    always_comb begin
        tx_s = TX_IDLE_LVL;
        case (state_s)
            ST_IDLE:   tx_s = TX_IDLE_LVL;
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shreg_s[0];
            ST_PARITY: tx_s = parity_s;
            ST_STOP:   tx_s = 1'b1;
            default:   tx_s = TX_IDLE_LVL;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shreg_r   <= '0;
            bit_cnt_r <= '0;
            parity_r  <= 1'b0;
            tx_r      <= TX_IDLE_LVL;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            shreg_r   <= shreg_s;
            bit_cnt_r <= bit_cnt_s;
            parity_r  <= parity_s;
            tx_r      <= tx_s;
            done_r    <= done_s;
        end
    end

    assign tx       = tx_r;
    assign done     = done_r;
    assign busy     = (state_r != ST_IDLE);
    assign in_ready = (state_r == ST_IDLE);

endmodule
